// File: rtl/glitch_sweep.sv
// Glitch parameter sweep sequencer: steps delay (inner loop) and width (outer loop) and fires one attempt per point.
// Optional build macro SWEEP_TRIGGER_EN gates each attempt on a rising edge of the external trig input.
module glitch_sweep (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] delay_min,
    input  logic [15:0] delay_max,
    input  logic [15:0] delay_step,
    input  logic [7:0]  width_min,
    input  logic [7:0]  width_max,
    input  logic [7:0]  width_step,
    input  logic [7:0]  mode_cfg,
    input  logic [15:0] holdoff,
    input  logic        trig,
    input  logic        gl_ready,
    output logic [15:0] gl_delay,
    output logic [7:0]  gl_width,
    output logic [7:0]  gl_mode,
    output logic        gl_en,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic [23:0] attempt_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        FIRE = 3'd2,
        WAIT = 3'd3,
        HOLD = 3'd4,
        STEP = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic        done_next;

    logic [15:0] dmin_reg, dmax_reg, dstep_reg, holdoff_reg, hold_cnt_reg;
    logic [7:0]  wmax_reg, wstep_reg;
    logic [15:0] delay_reg;
    logic [7:0]  width_reg, mode_reg;
    logic        en_reg, done_reg, cfg_err_reg, wait_first_reg;
    logic [23:0] cnt_reg;

    logic [16:0] delay_sum;
    logic [8:0]  width_sum;
    logic        delay_wrap, width_wrap, cfg_ok, accept, fire_ok;

    // Wider sums make a carry out of the field look like "past the maximum".
    assign delay_sum  = {1'b0, delay_reg} + {1'b0, dstep_reg};
    assign width_sum  = {1'b0, width_reg} + {1'b0, wstep_reg};
    assign delay_wrap = (dstep_reg == 16'd0) || (delay_sum > {1'b0, dmax_reg});
    assign width_wrap = (wstep_reg == 8'd0)  || (width_sum > {1'b0, wmax_reg});
    assign cfg_ok     = (delay_min <= delay_max) && (width_min <= width_max);
    assign accept     = (state_reg == IDLE) && start && !abort;

`ifdef SWEEP_TRIGGER_EN
    logic trig_d1_reg, trig_d2_reg, trig_seen_reg, trig_rise;

    assign trig_rise = trig_d1_reg & ~trig_d2_reg;
    assign fire_ok   = gl_ready && (trig_rise || trig_seen_reg);

    // Only edges observed while armed count; a level held from before ARM does not.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            trig_d1_reg   <= 1'b0;
            trig_d2_reg   <= 1'b0;
            trig_seen_reg <= 1'b0;
        end else begin
            trig_d1_reg <= trig;
            trig_d2_reg <= trig_d1_reg;
            if (state_reg != ARM)
                trig_seen_reg <= 1'b0;
            else if (trig_rise)
                trig_seen_reg <= 1'b1;
        end
    end
`else
    logic unused_trig;
    assign unused_trig = trig;
    assign fire_ok     = gl_ready;
`endif

    always_ff @(posedge clk_in) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        if (abort && (state_reg != IDLE)) begin
            state_next = IDLE;
            done_next  = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && cfg_ok)
                        state_next = ARM;
                    else if (accept)
                        done_next = 1'b1;
                end
                ARM:  if (fire_ok) state_next = FIRE;
                FIRE: state_next = WAIT;
                WAIT: begin
                    if (!wait_first_reg && gl_ready)
                        state_next = (holdoff_reg == 16'd0) ? STEP : HOLD;
                end
                HOLD: if (hold_cnt_reg == 16'd1) state_next = STEP;
                STEP: begin
                    if (delay_wrap && width_wrap) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ARM;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            dmin_reg       <= '0;
            dmax_reg       <= '0;
            dstep_reg      <= '0;
            holdoff_reg    <= '0;
            hold_cnt_reg   <= '0;
            wmax_reg       <= '0;
            wstep_reg      <= '0;
            delay_reg      <= '0;
            width_reg      <= '0;
            mode_reg       <= '0;
            en_reg         <= 1'b0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
            wait_first_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            en_reg         <= (state_next == FIRE);
            done_reg       <= done_next;
            wait_first_reg <= (state_reg == FIRE);

            if (accept) begin
                cfg_err_reg <= !cfg_ok;
                dmin_reg    <= delay_min;
                dmax_reg    <= delay_max;
                dstep_reg   <= delay_step;
                wmax_reg    <= width_max;
                wstep_reg   <= width_step;
                holdoff_reg <= holdoff;
                delay_reg   <= delay_min;
                width_reg   <= width_min;
                mode_reg    <= mode_cfg;
            end

            if ((state_reg == FIRE) && (cnt_reg != 24'hFFFFFF))
                cnt_reg <= cnt_reg + 24'd1;

            if ((state_reg == WAIT) && (state_next == HOLD))
                hold_cnt_reg <= holdoff_reg;
            else if (state_reg == HOLD)
                hold_cnt_reg <= hold_cnt_reg - 16'd1;

            // Parameters only move in STEP, so they stay put from ARM through WAIT.
            if ((state_reg == STEP) && (state_next == ARM)) begin
                if (delay_wrap) begin
                    delay_reg <= dmin_reg;
                    width_reg <= width_sum[7:0];
                end else begin
                    delay_reg <= delay_sum[15:0];
                end
            end
        end
    end

    assign gl_delay    = delay_reg;
    assign gl_width    = width_reg;
    assign gl_mode     = mode_reg;
    assign gl_en       = en_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign cfg_err     = cfg_err_reg;
    assign attempt_cnt = cnt_reg;

endmodule

// File: tb/tb_glitch_sweep.sv
// Bench for glitch_sweep: directed scenarios plus randomized sweeps checked against a loop-based attempt model.
`timescale 1ns/1ps
module tb_glitch_sweep;

    logic        clk = 1'b0;
    logic        rst, start, abort, trig, gl_ready;
    logic [15:0] delay_min, delay_max, delay_step, holdoff;
    logic [7:0]  width_min, width_max, width_step, mode_cfg;
    logic [15:0] gl_delay;
    logic [7:0]  gl_width, gl_mode;
    logic        gl_en, busy, done, cfg_err;
    logic [23:0] attempt_cnt;

    typedef struct { int d; int w; int m; int t; } att_t;
    att_t obs_q[$];
    att_t exp_q[$];
    att_t mon_a;

    int cyc = 0;
    int done_cnt = 0;
    int checks = 0;
    int failures = 0;
    int model_cnt = 0;
    int ready_mode = 1;
    bit trig_rand = 1'b0;

    glitch_sweep dut (
        .clk_in(clk), .rst(rst), .start(start), .abort(abort),
        .delay_min(delay_min), .delay_max(delay_max), .delay_step(delay_step),
        .width_min(width_min), .width_max(width_max), .width_step(width_step),
        .mode_cfg(mode_cfg), .holdoff(holdoff), .trig(trig), .gl_ready(gl_ready),
        .gl_delay(gl_delay), .gl_width(gl_width), .gl_mode(gl_mode), .gl_en(gl_en),
        .busy(busy), .done(done), .cfg_err(cfg_err), .attempt_cnt(attempt_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (gl_en === 1'b1) begin
            mon_a.d = int'(gl_delay);
            mon_a.w = int'(gl_width);
            mon_a.m = int'(gl_mode);
            mon_a.t = cyc;
            obs_q.push_back(mon_a);
        end
        if (done === 1'b1) done_cnt++;
    end

    // gl_ready/trig driver: mode 0 low, 1 high, 2 random; trig toggles randomly when enabled.
    initial begin
        gl_ready = 1'b1;
        trig = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                0:       gl_ready = 1'b0;
                1:       gl_ready = 1'b1;
                default: gl_ready = (($urandom % 4) != 0);
            endcase
            if (trig_rand) trig = $urandom % 2;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int dmin, input int dmax, input int dstep, input int wmin,
                           input int wmax, input int wstep, input int hold, input int mode);
        delay_min  = 16'(dmin);
        delay_max  = 16'(dmax);
        delay_step = 16'(dstep);
        width_min  = 8'(wmin);
        width_max  = 8'(wmax);
        width_step = 8'(wstep);
        holdoff    = 16'(hold);
        mode_cfg   = 8'(mode);
    endtask

    // Reference: enumerate sweep points with plain integer arithmetic.
    function automatic void build_expected(input int dmin, input int dmax, input int dstep,
                                           input int wmin, input int wmax, input int wstep,
                                           input int mode);
        att_t a;
        int d = dmin;
        int w = wmin;
        exp_q.delete();
        forever begin
            a.d = d; a.w = w; a.m = mode; a.t = 0;
            exp_q.push_back(a);
            if (dstep == 0 || d + dstep > dmax) begin
                d = dmin;
                if (wstep == 0 || w + wstep > wmax) break;
                w = w + wstep;
            end else begin
                d = d + dstep;
            end
        end
    endfunction

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic run_sweep(input string tag, input int dmin, input int dmax, input int dstep,
                             input int wmin, input int wmax, input int wstep, input int hold,
                             input int mode, input bit scramble);
        int d0;
        int s_cyc;
        int n;
        set_cfg(dmin, dmax, dstep, wmin, wmax, wstep, hold, mode);
        build_expected(dmin, dmax, dstep, wmin, wmax, wstep, mode);
        obs_q.delete();
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; s_cyc = cyc;
        @(negedge clk); start = 1'b0;
        if (scramble) begin
            set_cfg($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 9),
                    $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3),
                    $urandom_range(0, 9), $urandom_range(0, 255));
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        wait_done(tag, d0);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_attempts"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_delay[%0d]", tag, i), 32'(obs_q[i].d), 32'(exp_q[i].d));
            check($sformatf("%s_width[%0d]", tag, i), 32'(obs_q[i].w), 32'(exp_q[i].w));
            check($sformatf("%s_mode[%0d]", tag, i), 32'(obs_q[i].m), 32'(exp_q[i].m));
        end
        if (ready_mode == 1 && n > 0) begin
            check({tag, "_first_latency"}, 32'(obs_q[0].t - s_cyc), 32'd2);
            for (int i = 1; i < n; i++)
                check($sformatf("%s_gap[%0d]", tag, i), 32'(obs_q[i].t - obs_q[i-1].t), 32'(hold + 5));
        end
        model_cnt += exp_q.size();
        check({tag, "_attempt_cnt"}, 32'(attempt_cnt), 32'(model_cnt));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        $display("sweep %s: delay %0d..%0d/%0d width %0d..%0d/%0d hold %0d -> attempts=%0d expected=%0d",
                 tag, dmin, dmax, dstep, wmin, wmax, wstep, hold, obs_q.size(), exp_q.size());
    endtask

    initial begin
        int d0, n, r_cyc, dmin, dmax, wmin, wmax;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_gl_en", 32'(gl_en), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_cnt", 32'(attempt_cnt), 32'd0);
        check("rst_gl_delay", 32'(gl_delay), 32'd0);
        check("rst_gl_width", 32'(gl_width), 32'd0);
        check("rst_gl_mode", 32'(gl_mode), 32'd0);
        rst = 1'b0;
        $display("reset: outputs checked");

        // Basic six-point sweep, plus hard-coded corner values.
        ready_mode = 1;
        run_sweep("basic", 10, 30, 10, 1, 2, 1, 0, 8'hA5, 1'b0);
        if (obs_q.size() == 6) begin
            check("basic_p2_delay", 32'(obs_q[2].d), 32'd30);
            check("basic_p3_delay", 32'(obs_q[3].d), 32'd10);
            check("basic_p3_width", 32'(obs_q[3].w), 32'd2);
        end

        // Delay carry out of 16 bits reloads delay_min.
        run_sweep("carry", 16'hFFF0, 16'hFFFF, 16'h0020, 0, 2, 1, 1, 8'h3C, 1'b0);

        // Invalid range: error flag, done one cycle after start, no attempt.
        set_cfg(5, 4, 1, 0, 3, 1, 0, 1);
        obs_q.delete(); d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("cfgerr_done_pulse", 32'(done), 32'd1);
        check("cfgerr_flag", 32'(cfg_err), 32'd1);
        check("cfgerr_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("cfgerr_sticky", 32'(cfg_err), 32'd1);
        check("cfgerr_no_fire", 32'(obs_q.size()), 32'd0);
        check("cfgerr_done_once", 32'(done_cnt - d0), 32'd1);
        $display("cfg error: cfg_err=%0b attempts=%0d", cfg_err, obs_q.size());

        // Following valid start clears cfg_err (checked inside run_sweep).
        run_sweep("clear_err", 0, 4, 2, 9, 9, 0, 2, 8'h11, 1'b0);

        // WAIT holds while gl_ready is low; holdoff=3 spaces the next attempt.
        set_cfg(100, 100, 1, 7, 8, 1, 3, 8'h5A);
        obs_q.delete(); d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (obs_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
        check("stall_first_fire", 32'(obs_q.size()), 32'd1);
        ready_mode = 0;
        repeat (50) @(negedge clk);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_no_fire", 32'(obs_q.size()), 32'd1);
        check("stall_no_done", 32'(done_cnt - d0), 32'd0);
        ready_mode = 1; r_cyc = cyc;
        n = 0;
        while (obs_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
        check("stall_second_fire", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            check("stall_hold_timing", 32'(obs_q[1].t - r_cyc), 32'd6);
            check("stall_second_width", 32'(obs_q[1].w), 32'd8);
        end
        wait_done("stall", d0);
        model_cnt += 2;
        check("stall_cnt", 32'(attempt_cnt), 32'(model_cnt));
        $display("stall: attempts=%0d", obs_q.size());

        // Abort during HOLD.
        set_cfg(0, 50, 10, 0, 0, 1, 20, 8'h77);
        obs_q.delete(); d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (obs_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd1);
        check("abort_gl_en", 32'(gl_en), 32'd0);
        repeat (30) @(negedge clk);
        check("abort_done_once", 32'(done_cnt - d0), 32'd1);
        check("abort_no_more_fire", 32'(obs_q.size()), 32'd1);
        model_cnt += 1;
        check("abort_cnt", 32'(attempt_cnt), 32'(model_cnt));

        // abort together with start in IDLE: nothing happens.
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("idle_abort_no_done", 32'(done_cnt - d0), 32'd0);
        $display("abort: done pulses=1 attempts=%0d", obs_q.size());

        // Reset during WAIT of a new sweep.
        set_cfg(3, 9, 3, 1, 1, 1, 0, 8'hC3);
        obs_q.delete(); d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (obs_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
        ready_mode = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_cnt = 0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_gl_en", 32'(gl_en), 32'd0);
        check("midrst_cnt", 32'(attempt_cnt), 32'd0);
        check("midrst_gl_delay", 32'(gl_delay), 32'd0);
        check("midrst_gl_width", 32'(gl_width), 32'd0);
        check("midrst_gl_mode", 32'(gl_mode), 32'd0);
        ready_mode = 1;
        repeat (10) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_no_fire", 32'(obs_q.size()), 32'd1);
        $display("mid-sweep reset: outputs cleared");

        // Randomized sweeps with trig noise, ignored restarts and random ready.
        trig_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dmin = ($urandom % 2) ? $urandom_range(0, 60) : $urandom_range(65480, 65535);
            dmax = dmin + $urandom_range(0, 40);
            if (dmax > 65535) dmax = 65535;
            wmin = $urandom_range(0, 255);
            wmax = wmin + $urandom_range(0, 4);
            if (wmax > 255) wmax = 255;
            ready_mode = (i % 3 == 2) ? 2 : 1;
            run_sweep($sformatf("rand%0d", i), dmin, dmax,
                      (($urandom % 8) == 0) ? 0 : $urandom_range(1, 15),
                      wmin, wmax, (($urandom % 8) == 0) ? 0 : $urandom_range(1, 3),
                      $urandom_range(0, 3), $urandom_range(0, 255), 1'(i % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
